// File: rtl/fetch_controller.sv
// fetch_controller
//
// Instruction-fetch sequencer sitting between the PC logic and a synchronous
// program memory. Owns the program counter, captures returned words and hands
// them to decode over a valid/ready handshake. Supports branch redirects, a
// halt opcode that stops fetch, and a resume input that restarts it.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   res_n          asynchronous active-low reset
//   pc             program memory address (the internal program counter)
//   ir             word returned by memory, registered one edge after pc
//   instr          captured instruction to decode
//   instr_pc       address instr was fetched from
//   instr_valid    instr/instr_pc are valid
//   instr_ready    decode accepts instr this cycle
//   branch_en      redirect fetch to branch_target this cycle
//   branch_target  redirect address
//   resume         leave the halted state
//   halted         controller is halted
module fetch_controller #(
  parameter int unsigned           PC_WIDTH    = 8,
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
  input  logic                  clk,
  input  logic                  res_n,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic [DATA_WIDTH-1:0] ir,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]   instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  branch_en,
  input  logic [PC_WIDTH-1:0]   branch_target,
  input  logic                  resume,
  output logic                  halted
);

  localparam logic [PC_WIDTH-1:0] PcOne = PC_WIDTH'(1);

  typedef enum logic [1:0] {
    StFetch   = 2'd0,
    StCapture = 2'd1,
    StIssue   = 2'd2,
    StHalt    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]   instr_pc_q, instr_pc_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  halted_q, halted_d;

  logic                  is_halt_op;

  assign is_halt_op = (ir[DATA_WIDTH-1 -: 4] == HALT_OPCODE);

  // State register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        state_d = branch_en ? StFetch : StCapture;
      end
      StCapture: begin
        if (branch_en) begin
          state_d = StFetch;
        end else if (is_halt_op) begin
          state_d = StHalt;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        // Branch also counts as acceptance, so both exits go to FETCH.
        if (branch_en || instr_ready) begin
          state_d = StFetch;
        end
      end
      StHalt: begin
        if (resume) begin
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // Datapath / output register next values
  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    unique case (state_q)
      StFetch: begin
        if (branch_en) begin
          pc_d = branch_target;
        end
      end
      StCapture: begin
        if (branch_en) begin
          // In-flight word is dropped.
          pc_d = branch_target;
        end else if (is_halt_op) begin
          // The halt word is consumed but never issued.
          pc_d     = pc_q + PcOne;
          halted_d = 1'b1;
        end else begin
          instr_d       = ir;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + PcOne;
        end
      end
      StIssue: begin
        if (branch_en) begin
          pc_d          = branch_target;
          instr_valid_d = 1'b0;
        end else if (instr_ready) begin
          instr_valid_d = 1'b0;
        end
      end
      StHalt: begin
        // branch_en deliberately ignored while halted.
        if (resume) begin
          halted_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: program memory model, scoreboard of
// expected issued instructions, and one task per scenario.
module tb_fetch_controller;

  logic        clk;
  logic        res_n;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_en;
  logic [7:0]  branch_target;
  logic        resume;
  logic        halted;

  int n_tests;
  int n_fail;

  logic [15:0] mem [256];
  logic [23:0] exp_q [$];   // {instr, instr_pc}
  logic        prev_valid;

  fetch_controller #(
    .PC_WIDTH   (8),
    .DATA_WIDTH (16),
    .RESET_PC   (8'h00),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk          (clk),
    .res_n        (res_n),
    .pc           (pc),
    .ir           (ir),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_en    (branch_en),
    .branch_target(branch_target),
    .resume       (resume),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory
  always @(posedge clk) ir <= mem[pc];

  // Scoreboard: every new issue (valid rising) must match the queue head.
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got instr=%h pc=%h, required no issue", instr, instr_pc);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        if ({instr, instr_pc} !== e) begin
          n_fail++;
          $display("FAIL sb_issue: got instr=%h pc=%h, required instr=%h pc=%h",
                   instr, instr_pc, e[23:8], e[7:0]);
        end
      end
    end
    prev_valid <= instr_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first FETCH cycle after reset release.
  task automatic do_reset();
    res_n = 1'b0;
    tick();
    tick();
    exp_q.delete();
    res_n = 1'b1;
  endtask

  task automatic test_reset();
    res_n = 1'b0;
    #1;
    n_tests++;
    if ({instr_valid, halted, pc, instr, instr_pc} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_vals: got v=%b h=%b pc=%h instr=%h ipc=%h, required all zero",
               instr_valid, halted, pc, instr, instr_pc);
    end
  endtask

  task automatic test_sequential();
    instr_ready = 1'b1;
    do_reset();
    exp_q.push_back({16'h4903, 8'h00});
    exp_q.push_back({16'h4A14, 8'h01});
    exp_q.push_back({16'h4BF0, 8'h02});
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_tests++;
      if (instr_valid !== (c % 3 == 2)) begin
        n_fail++;
        $display("FAIL seq_valid_c%0d: got %b, required %b", c, instr_valid, (c % 3 == 2));
      end
    end
    n_tests++;
    if (pc !== 8'h03) begin
      n_fail++;
      $display("FAIL seq_pc: got %h, required 03", pc);
    end
    instr_ready = 1'b0;
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL seq_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b1;
    do_reset();
    exp_q.push_back({16'h4903, 8'h00});
    exp_q.push_back({16'h4A14, 8'h01});
    exp_q.push_back({16'h4BF0, 8'h02});
    for (int c = 1; c <= 4; c++) tick();
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if ({instr_valid, instr, instr_pc, pc} !== {1'b1, 16'h4A14, 8'h01, 8'h02}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b instr=%h ipc=%h pc=%h, required 1 4a14 01 02",
                 k, instr_valid, instr, instr_pc, pc);
      end
    end
    instr_ready = 1'b1;
    tick();
    n_tests++;
    if ({instr_valid, pc} !== {1'b0, 8'h02}) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b pc=%h, required 0 02", instr_valid, pc);
    end
    tick();
    tick();
    instr_ready = 1'b0;
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_branch_issue();
    instr_ready = 1'b1;
    do_reset();
    exp_q.push_back({16'h4903, 8'h00});
    exp_q.push_back({16'h4A14, 8'h01});
    exp_q.push_back({16'h8008, 8'h0A});
    for (int c = 1; c <= 5; c++) tick();
    branch_en     = 1'b1;
    branch_target = 8'h0A;
    tick();
    branch_en = 1'b0;
    n_tests++;
    if ({instr_valid, pc} !== {1'b0, 8'h0A}) begin
      n_fail++;
      $display("FAIL br_issue_redirect: got v=%b pc=%h, required 0 0a", instr_valid, pc);
    end
    tick();
    tick();
    n_tests++;
    if (instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL br_issue_latency: got v=%b, required 1", instr_valid);
    end
    instr_ready = 1'b0;
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL br_issue_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_branch_capture();
    instr_ready = 1'b1;
    do_reset();
    exp_q.push_back({16'h4903, 8'h00});
    exp_q.push_back({16'h8119, 8'h0B});
    for (int c = 1; c <= 4; c++) tick();
    branch_en     = 1'b1;
    branch_target = 8'h0B;
    tick();
    branch_en = 1'b0;
    n_tests++;
    if ({instr_valid, pc} !== {1'b0, 8'h0B}) begin
      n_fail++;
      $display("FAIL br_cap_redirect: got v=%b pc=%h, required 0 0b", instr_valid, pc);
    end
    tick();
    tick();
    instr_ready = 1'b0;
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL br_cap_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_halt_resume();
    instr_ready = 1'b1;
    do_reset();
    exp_q.push_back({16'h4903, 8'h00});
    exp_q.push_back({16'h4A14, 8'h01});
    exp_q.push_back({16'h4BF0, 8'h02});
    exp_q.push_back({16'h4C55, 8'h04});
    for (int i = 0; i < 20 && !halted; i++) tick();
    n_tests++;
    if (halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_enter: got halted=%b, required 1", halted);
    end
    for (int k = 0; k < 10; k++) begin
      // Branch requests while halted must be ignored.
      branch_en     = (k >= 5);
      branch_target = 8'h0A;
      tick();
      n_tests++;
      if ({halted, instr_valid, pc} !== {1'b1, 1'b0, 8'h04}) begin
        n_fail++;
        $display("FAIL halt_hold_%0d: got h=%b v=%b pc=%h, required 1 0 04",
                 k, halted, instr_valid, pc);
      end
    end
    branch_en = 1'b0;
    resume    = 1'b1;
    tick();
    resume = 1'b0;
    n_tests++;
    if ({halted, pc} !== {1'b0, 8'h04}) begin
      n_fail++;
      $display("FAIL resume_fetch: got h=%b pc=%h, required 0 04", halted, pc);
    end
    tick();
    tick();
    n_tests++;
    if (instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_latency: got v=%b, required 1", instr_valid);
    end
    instr_ready = 1'b0;
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL halt_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    instr_ready = 1'b1;
    do_reset();
    exp_q.push_back({16'h7ABC, 8'hFF});
    exp_q.push_back({16'h4903, 8'h00});
    branch_en     = 1'b1;
    branch_target = 8'hFF;
    tick();
    branch_en = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({instr_valid, pc} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL wrap_pc: got v=%b pc=%h, required 1 00", instr_valid, pc);
    end
    tick();
    tick();
    tick();
    instr_ready = 1'b0;
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    do_reset();
    exp_q.push_back({16'h4903, 8'h00});
    exp_q.push_back({16'h4A14, 8'h01});
    for (int c = 1; c <= 4; c++) tick();
    instr_ready = 1'b0;
    tick();
    tick();
    #2;
    res_n = 1'b0;
    #1;
    n_tests++;
    if ({instr_valid, halted, pc, instr_pc} !== 18'd0) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b h=%b pc=%h ipc=%h, required 0 0 00 00",
               instr_valid, halted, pc, instr_pc);
    end
    tick();
    exp_q.delete();
    exp_q.push_back({16'h4903, 8'h00});
    res_n       = 1'b1;
    instr_ready = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({instr_valid, pc} !== {1'b1, 8'h01}) begin
      n_fail++;
      $display("FAIL async_restart: got v=%b pc=%h, required 1 01", instr_valid, pc);
    end
    instr_ready = 1'b0;
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL async_drain: got %0d left, required 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    prev_valid    = 1'b0;
    res_n         = 1'b0;
    instr_ready   = 1'b0;
    branch_en     = 1'b0;
    branch_target = 8'h00;
    resume        = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[8'h00] = 16'h4903;
    mem[8'h01] = 16'h4A14;
    mem[8'h02] = 16'h4BF0;
    mem[8'h03] = 16'hF000;
    mem[8'h04] = 16'h4C55;
    mem[8'h0A] = 16'h8008;
    mem[8'h0B] = 16'h8119;
    mem[8'hFF] = 16'h7ABC;

    test_reset();
    test_sequential();
    test_backpressure();
    test_branch_issue();
    test_branch_capture();
    test_halt_resume();
    test_wrap();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
